// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage RISC-V pipeline: load-use stalls,
// EX redirect flushes, data-memory wait stalls with timeout.
module pipe_hazard_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             ex_redirect,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam int WW = $clog2(WAIT_MAX + 1) + 1;
  localparam logic [WW-1:0] WMAX = WW'(WAIT_MAX);

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            stall_inc, flush_inc, err_set;
  logic            load_use;

  assign load_use = idex_memread && (idex_rd != 5'd0) &&
                    ((idex_rd == ifid_rs1) ||
                     (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  assign state = state_q;

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    state_d      = state_q;
    wait_d       = wait_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    err_set      = 1'b0;
    if (reset) begin
      state_d = RUN;
      wait_d  = '0;
    end else begin
      case (state_q)
        ERROR: begin
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          idex_en      = 1'b0;
          exmem_en     = 1'b0;
          memwb_bubble = 1'b1;
        end
        RUN, MEM_WAIT: begin
          if (dmem_busy) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            stall_inc    = 1'b1;
            if (state_q == RUN) begin
              state_d = MEM_WAIT;
              wait_d  = WW'(1);
            end else if (wait_q == WMAX) begin
              state_d = ERROR;
              err_set = 1'b1;
            end else begin
              wait_d = wait_q + WW'(1);
            end
          end else begin
            // A finished wait resumes normal hazard handling this cycle
            state_d = RUN;
            wait_d  = '0;
            if (ex_redirect) begin
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
              flush_inc  = 1'b1;
            end else if (load_use) begin
              pc_en      = 1'b0;
              ifid_en    = 1'b0;
              idex_flush = 1'b1;
              stall_inc  = 1'b1;
            end
          end
        end
        default: begin
          state_d = RUN;
          wait_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (stall_inc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (err_set)
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second instance with
// 4-bit counters covers counter saturation.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       ifid_uses_rs2, idex_memread;
  logic       ex_redirect, dmem_busy;

  logic        pc_en, ifid_en, idex_en, exmem_en;
  logic        ifid_flush, idex_flush, memwb_bubble;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;
  logic        timeout_err;

  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en;
  logic        s_ifid_flush, s_idex_flush, s_memwb_bubble;
  logic [1:0]  s_state;
  logic [3:0]  s_stall_cnt, s_flush_cnt;
  logic        s_timeout_err;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] O_RUN   = 7'b1111000;
  localparam logic [6:0] O_LU    = 7'b0011010;
  localparam logic [6:0] O_REDIR = 7'b1111110;
  localparam logic [6:0] O_STALL = 7'b0000001;

  wire [6:0] outs = {pc_en, ifid_en, idex_en, exmem_en,
                     ifid_flush, idex_flush, memwb_bubble};

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs2(ifid_uses_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_bubble(memwb_bubble), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .timeout_err(timeout_err)
  );

  pipe_hazard_ctrl #(.WAIT_MAX(15), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs2(ifid_uses_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en),
    .idex_en(s_idex_en), .exmem_en(s_exmem_en),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .memwb_bubble(s_memwb_bubble), .state(s_state),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt),
    .timeout_err(s_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
    ifid_uses_rs2 = 1'b0; idex_memread = 1'b0; idex_rd = 5'd0;
    ex_redirect = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; dmem_busy = 1'b1; ex_redirect = 1'b1;
    idex_memread = 1'b1; idex_rd = 5'd3; ifid_rs1 = 5'd3;
    #2;
    total++; if (outs !== O_RUN) begin bad++;
      $display("FAIL reset_outs got=%b exp=%b", outs, O_RUN); end
    tick();
    total++; if (state !== 2'd0) begin bad++;
      $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if ({stall_cnt, flush_cnt} !== 32'd0) begin bad++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    total++; if (timeout_err !== 1'b0) begin bad++;
      $display("FAIL reset_err got=%b exp=0", timeout_err); end
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5; #2;
    total++; if (outs !== O_LU) begin bad++;
      $display("FAIL lu_rs1_outs got=%b exp=%b", outs, O_LU); end
    tick(); idle(); #2;
    total++; if (stall_cnt !== 16'd1) begin bad++;
      $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    total++; if (outs !== O_RUN) begin bad++;
      $display("FAIL lu_one_cycle got=%b exp=%b", outs, O_RUN); end
    idex_memread = 1'b1; idex_rd = 5'd9; ifid_rs2 = 5'd9;
    ifid_uses_rs2 = 1'b1; #2;
    total++; if (outs !== O_LU) begin bad++;
      $display("FAIL lu_rs2_outs got=%b exp=%b", outs, O_LU); end
    tick(); idle();
    total++; if (stall_cnt !== 16'd2) begin bad++;
      $display("FAIL lu_rs2_cnt got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_no_stall();
    do_reset();
    idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; #2;
    total++; if (outs !== O_RUN) begin bad++;
      $display("FAIL x0_outs got=%b exp=%b", outs, O_RUN); end
    tick();
    idex_rd = 5'd7; ifid_rs1 = 5'd1; ifid_rs2 = 5'd7;
    ifid_uses_rs2 = 1'b0; #2;
    total++; if (outs !== O_RUN) begin bad++;
      $display("FAIL rs2_unused_outs got=%b exp=%b", outs, O_RUN); end
    tick();
    idex_memread = 1'b0; ifid_rs1 = 5'd7; #2;
    total++; if (outs !== O_RUN) begin bad++;
      $display("FAIL no_memread_outs got=%b exp=%b", outs, O_RUN); end
    tick(); idle();
    total++; if (stall_cnt !== 16'd0) begin bad++;
      $display("FAIL no_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_redirect();
    do_reset();
    ex_redirect = 1'b1; idex_memread = 1'b1;
    idex_rd = 5'd5; ifid_rs1 = 5'd5; #2;
    total++; if (outs !== O_REDIR) begin bad++;
      $display("FAIL redir_lu_outs got=%b exp=%b", outs, O_REDIR); end
    tick(); idle();
    total++; if (flush_cnt !== 16'd1) begin bad++;
      $display("FAIL redir_flush_cnt got=%0d exp=1", flush_cnt); end
    total++; if (stall_cnt !== 16'd0) begin bad++;
      $display("FAIL redir_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      dmem_busy = 1'b1; ex_redirect = (i == 1);
      idex_memread = 1'b1; idex_rd = 5'd4; ifid_rs1 = 5'd4; #2;
      total++; if (outs !== O_STALL) begin bad++;
        $display("FAIL memwait_outs[%0d] got=%b exp=%b", i, outs, O_STALL); end
      tick();
      total++; if (state !== 2'd1) begin bad++;
        $display("FAIL memwait_state[%0d] got=%0d exp=1", i, state); end
    end
    idle(); ex_redirect = 1'b1; #2;
    total++; if (outs !== O_REDIR) begin bad++;
      $display("FAIL memwait_exit_outs got=%b exp=%b", outs, O_REDIR); end
    tick(); idle();
    total++; if (state !== 2'd0) begin bad++;
      $display("FAIL memwait_exit_state got=%0d exp=0", state); end
    total++; if (stall_cnt !== 16'd3) begin bad++;
      $display("FAIL memwait_stall_cnt got=%0d exp=3", stall_cnt); end
    total++; if (flush_cnt !== 16'd1) begin bad++;
      $display("FAIL memwait_flush_cnt got=%0d exp=1", flush_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_busy = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    total++; if (state !== 2'd1 || timeout_err !== 1'b0) begin bad++;
      $display("FAIL pre_timeout got=%0d/%b exp=1/0", state, timeout_err); end
    tick();
    total++; if (state !== 2'd2) begin bad++;
      $display("FAIL timeout_state got=%0d exp=2", state); end
    total++; if (timeout_err !== 1'b1) begin bad++;
      $display("FAIL timeout_err got=%b exp=1", timeout_err); end
    total++; if (stall_cnt !== 16'd16) begin bad++;
      $display("FAIL timeout_stall_cnt got=%0d exp=16", stall_cnt); end
    idle(); ex_redirect = 1'b1; #2;
    total++; if (outs !== O_STALL) begin bad++;
      $display("FAIL error_outs got=%b exp=%b", outs, O_STALL); end
    tick(); tick();
    total++; if (state !== 2'd2 || flush_cnt !== 16'd0) begin bad++;
      $display("FAIL error_hold got=%0d/%0d exp=2/0", state, flush_cnt); end
    idle(); reset = 1'b1; #2;
    total++; if (outs !== O_RUN) begin bad++;
      $display("FAIL error_reset_outs got=%b exp=%b", outs, O_RUN); end
    tick(); idle();
    total++; if (state !== 2'd0 || timeout_err !== 1'b0) begin bad++;
      $display("FAIL error_reset got=%0d/%b exp=0/0", state, timeout_err); end
    total++; if ({stall_cnt, flush_cnt} !== 32'd0) begin bad++;
      $display("FAIL error_reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    idex_memread = 1'b1; idex_rd = 5'd12; ifid_rs1 = 5'd12;
    for (int i = 0; i < 14; i++) tick();
    total++; if (s_stall_cnt !== 4'd14) begin bad++;
      $display("FAIL sat_pre got=%0d exp=14", s_stall_cnt); end
    for (int i = 0; i < 6; i++) tick();
    idle();
    total++; if (s_stall_cnt !== 4'd15) begin bad++;
      $display("FAIL sat_small got=%0d exp=15", s_stall_cnt); end
    total++; if (stall_cnt !== 16'd20) begin bad++;
      $display("FAIL sat_wide got=%0d exp=20", stall_cnt); end
    ex_redirect = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    idle();
    total++; if (s_flush_cnt !== 4'd15) begin bad++;
      $display("FAIL sat_flush got=%0d exp=15", s_flush_cnt); end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_no_stall();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
